idex_pipe_reg: RTL and testbench

ID/EX pipeline register for the pipelined RISC-V core. It captures decoded operands and control from the decode stage behind a valid/ready handshake, then presents them to the execute stage. It also produces registered 2-bit forwarding selects that drive the operand `MUX4` instances at the ALU inputs, and it stalls decode on load-use hazards. A flush input from the branch-resolution logic in EX squashes wrong-path work.

---
 rtl/riscv_pipe_pkg.sv | 20 ++
 rtl/fwd_select.sv | 31 +++
 rtl/idex_pipe_reg.sv | 162 ++++++++++++++++
 tb/tb_idex_pipe_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: operand-mux select encodings, register-index width,
// default control-bundle width and the RAW-match helper.
package riscv_pipe_pkg;

  localparam int unsigned REGW      = 5;
  localparam int unsigned CTRLW_DEF = 8;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // A producer only counts if it is valid, writes, and does not target x0.
  function automatic logic raw_hit(input logic [REGW-1:0] src,
                                   input logic [REGW-1:0] rd,
                                   input logic            wr,
                                   input logic            vld);
    return wr && vld && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: the EX-stage producer outranks the MEM-stage producer.
module fwd_select
  import riscv_pipe_pkg::*;
(
  input  logic [REGW-1:0] src_i,
  input  logic [REGW-1:0] ex_rd_i,
  input  logic            ex_write_i,
  input  logic            ex_valid_i,
  input  logic [REGW-1:0] mem_rd_i,
  input  logic            mem_write_i,
  input  logic            mem_valid_i,
  output logic [1:0]      sel_o,
  output logic            hit_o
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = raw_hit(src_i, ex_rd_i, ex_write_i, ex_valid_i);
    mem_hit = raw_hit(src_i, mem_rd_i, mem_write_i, mem_valid_i);
    sel_o   = FWD_REG;
    if (ex_hit) begin
      sel_o = FWD_MEM;
    end else if (mem_hit) begin
      sel_o = FWD_WB;
    end
    hit_o = ex_hit || mem_hit;
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with registered forwarding selects and hazard stall.
// Build option IDEX_FORWARDING_EN: forwarding plus load-use stall; otherwise stall on any RAW.
module idex_pipe_reg
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTRLW = CTRLW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [REGW-1:0]  in_rs1,
  input  logic [REGW-1:0]  in_rs2,
  input  logic [REGW-1:0]  in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_read,
  input  logic [CTRLW-1:0] in_ctrl,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_rs1_data,
  output logic [WIDTH-1:0] out_rs2_data,
  output logic [WIDTH-1:0] out_imm,
  output logic [REGW-1:0]  out_rd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic [CTRLW-1:0] out_ctrl,
  input  logic [REGW-1:0]  mem_rd,
  input  logic             mem_reg_write,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
);

`ifdef IDEX_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d, rs1d_q, rs1d_d, rs2d_q, rs2d_d, imm_q, imm_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic             rw_q, rw_d, mr_q, mr_d;
  logic [CTRLW-1:0] ctrl_q, ctrl_d;
  logic [1:0]       fa_q, fa_d, fb_q, fb_d;

  logic [1:0] sel_a, sel_b;
  logic       hit_a, hit_b;
  logic       stall, load_use, capture;

  // The MEM stage carries no separate valid; its write flag is only set for real work.
  fwd_select u_fwd_a (
    .src_i      (in_rs1),
    .ex_rd_i    (rd_q),
    .ex_write_i (rw_q),
    .ex_valid_i (valid_q),
    .mem_rd_i   (mem_rd),
    .mem_write_i(mem_reg_write),
    .mem_valid_i(1'b1),
    .sel_o      (sel_a),
    .hit_o      (hit_a)
  );

  fwd_select u_fwd_b (
    .src_i      (in_rs2),
    .ex_rd_i    (rd_q),
    .ex_write_i (rw_q),
    .ex_valid_i (valid_q),
    .mem_rd_i   (mem_rd),
    .mem_write_i(mem_reg_write),
    .mem_valid_i(1'b1),
    .sel_o      (sel_b),
    .hit_o      (hit_b)
  );

  always_comb begin
    load_use = valid_q && mr_q && ((sel_a == FWD_MEM) || (sel_b == FWD_MEM));
    stall    = FWD_ON ? load_use : (hit_a || hit_b);
    in_ready = (!valid_q || out_ready) && !stall;
    capture  = in_valid && in_ready && !flush;

    valid_d = valid_q;
    pc_d    = pc_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    ctrl_d  = ctrl_q;
    fa_d    = fa_q;
    fb_d    = fb_q;

    // Flush only clears valid; payload is left untouched so squashed work never shows.
    if (flush) begin
      valid_d = 1'b0;
    end else if (valid_q && !out_ready) begin
      valid_d = 1'b1;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      rs1d_d  = in_rs1_data;
      rs2d_d  = in_rs2_data;
      imm_d   = in_imm;
      rd_d    = in_rd;
      rw_d    = in_reg_write;
      mr_d    = in_mem_read;
      ctrl_d  = in_ctrl;
      fa_d    = FWD_ON ? sel_a : FWD_REG;
      fb_d    = FWD_ON ? sel_b : FWD_REG;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      ctrl_q  <= '0;
      fa_q    <= FWD_REG;
      fb_q    <= FWD_REG;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      ctrl_q  <= ctrl_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1_data  = rs1d_q;
  assign out_rs2_data  = rs2d_q;
  assign out_imm       = imm_q;
  assign out_rd        = rd_q;
  assign out_reg_write = rw_q;
  assign out_mem_read  = mr_q;
  assign out_ctrl      = ctrl_q;
  assign fwd_a_sel     = fa_q;
  assign fwd_b_sel     = fb_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Scoreboard bench for idex_pipe_reg; expectations follow IDEX_FORWARDING_EN when defined.
module tb_idex_pipe_reg;

`ifdef IDEX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [7:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_reg_write = 1'b0, in_mem_read = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read;
  logic [7:0]  out_ctrl;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  idex_pipe_reg #(.WIDTH(32), .CTRLW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_ctrl(out_ctrl),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  // Downstream MEM stage: advances with out_ready like the rest of the back end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
    end else if (out_ready) begin
      mem_rd        <= out_rd;
      mem_reg_write <= out_valid && out_reg_write;
    end
  end

  // Monitor: an instruction leaves EX whenever it is valid and the back end advances.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t act, want;
      act = '{pc: out_pc, rs1d: out_rs1_data, rs2d: out_rs2_data, imm: out_imm, rd: out_rd,
              rw: out_reg_write, mr: out_mem_read, ctrl: out_ctrl, fa: fwd_a_sel, fb: fwd_b_sel};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got pc=%h (no instruction expected)", out_pc);
      end else begin
        want = exp_q.pop_front();
        if (act !== want) begin
          bad++;
          $display("FAIL sb pc=%h: got %h fa=%0d fb=%0d, want %h fa=%0d fb=%0d",
                   want.pc, act, act.fa, act.fb, want, want.fa, want.fb);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_reg_write = 1'b0; in_mem_read = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction and wait (bounded) for acceptance; called at posedge+1.
  task automatic issue(input string tag, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr,
                       input logic [1:0] ea, input logic [1:0] eb, input int exp_stalls);
    int   stalls;
    bit   done;
    exp_t e;
    in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr;
    in_rs1_data = pc ^ 32'hA5A5_0000;
    in_rs2_data = pc + 32'd1;
    in_imm      = pc << 4;
    in_ctrl     = pc[7:0] ^ 8'h3C;
    e = '{pc: pc, rs1d: pc ^ 32'hA5A5_0000, rs2d: pc + 32'd1, imm: pc << 4, rd: rd,
          rw: rw, mr: mr, ctrl: pc[7:0] ^ 8'h3C, fa: ea, fb: eb};
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_accept: got no acceptance within 10 cycles want accepted", tag);
      in_valid = 1'b0;
    end
    chk({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_fwd", 64'({fwd_a_sel, fwd_b_sel}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Back-to-back dependency on x5
    issue("b2b_w", 32'h10, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 2'd0, 2'd0, 0);
    issue("b2b_r", 32'h14, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, FWD ? 2'd1 : 2'd0, 2'd0, FWD ? 0 : 2);
    idle(3);

    // Distance-2 dependency on x7 through rs2
    issue("d2_w", 32'h20, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 2'd0, 2'd0, 0);
    issue("d2_m", 32'h24, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 2'd0, 2'd0, 0);
    issue("d2_r", 32'h28, 5'd9, 5'd7, 5'd10, 1'b1, 1'b0, 2'd0, FWD ? 2'd2 : 2'd0, FWD ? 0 : 1);
    idle(3);

    // Load-use on x3
    issue("lu_ld", 32'h30, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 2'd0, 2'd0, 0);
    issue("lu_use", 32'h34, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, FWD ? 2'd2 : 2'd0, 2'd0, FWD ? 1 : 2);
    idle(3);

    // x0 destination never forwards or stalls
    issue("x0_w", 32'h38, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 0);
    issue("x0_r", 32'h3C, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 2'd0, 2'd0, 0);
    idle(3);

    // Flush squashes the offered pc 0x40
    issue("fl_a", 32'h50, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 2'd0, 2'd0, 0);
    in_valid = 1'b1; in_pc = 32'h40; in_rs1 = '0; in_rs2 = '0; in_rd = 5'd12;
    in_reg_write = 1'b1; in_mem_read = 1'b0; flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_pc", 64'(out_pc), 64'h50);
    idle(3);

    // Hold for 3 cycles, then asynchronous reset mid-hold
    issue("hold", 32'h60, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0, 2'd0, 2'd0, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h64; in_rs1 = '0; in_rs2 = '0; in_rd = 5'd14;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_out", 64'({out_valid, out_pc, out_rd, fwd_a_sel, fwd_b_sel}),
          64'({1'b1, 32'h60, 5'd13, 2'd0, 2'd0}));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", 64'({out_valid, out_pc, out_rd, out_reg_write, out_mem_read}), 64'd0);
    chk("arst_ctrl_fwd", 64'({out_ctrl, fwd_a_sel, fwd_b_sel}), 64'd0);
    exp_q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
